// File: rtl/nv_nvdla_pdp_rdma_rd_arb.sv
// Credit-aware round-robin arbiter that steers PDP RDMA read requests onto the MCIF or CVIF
// read-request port, gated by per-port latency-FIFO credit pools.
module nv_nvdla_pdp_rdma_rd_arb #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned MC_CDT = 128,
    parameter int unsigned CV_CDT = 128
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*79-1:0]   req_pd,
    input  logic [NREQ-1:0]      req_ram_type,
    output logic                 pdp2mcif_rd_req_valid,
    input  logic                 pdp2mcif_rd_req_ready,
    output logic [78:0]          pdp2mcif_rd_req_pd,
    output logic                 pdp2cvif_rd_req_valid,
    input  logic                 pdp2cvif_rd_req_ready,
    output logic [78:0]          pdp2cvif_rd_req_pd,
    input  logic                 mcif_lat_fifo_pop,
    input  logic                 cvif_lat_fifo_pop,
    output logic                 arb2cq_valid,
    output logic [1:0]           arb2cq_id,
    output logic [8:0]           mc_cdt_avail,
    output logic [8:0]           cv_cdt_avail
);

    localparam logic [8:0] McFull = 9'(MC_CDT);
    localparam logic [8:0] CvFull = 9'(CV_CDT);

    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic        mc_valid_q, mc_valid_d;
    logic [78:0] mc_pd_q, mc_pd_d;
    logic        cv_valid_q, cv_valid_d;
    logic [78:0] cv_pd_q, cv_pd_d;
    logic [8:0]  mc_cdt_q, mc_cdt_d;
    logic [8:0]  cv_cdt_q, cv_cdt_d;
    logic        cq_valid_q, cq_valid_d;
    logic [1:0]  cq_id_q, cq_id_d;

    logic [15:0]     need [NREQ];
    logic [NREQ-1:0] elig;
    logic            mc_free, cv_free;
    logic            found;
    logic [1:0]      win;
    int unsigned     arb_idx;
    logic [15:0]     win_need;
    logic [78:0]     win_pd;
    logic            acc_mc, acc_cv;
    logic [15:0]     mc_dec, cv_dec, mc_inc, cv_inc;

    // A port register can take a new request when empty or draining this cycle.
    assign mc_free = !mc_valid_q || pdp2mcif_rd_req_ready;
    assign cv_free = !cv_valid_q || pdp2cvif_rd_req_ready;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            need[i] = 16'(req_pd[79*i+64 +: 15]) + 16'd1;
            if (req_ram_type[i]) begin
                elig[i] = req_valid[i] && mc_free && (need[i] <= {7'd0, mc_cdt_q});
            end else begin
                elig[i] = req_valid[i] && cv_free && (need[i] <= {7'd0, cv_cdt_q});
            end
        end
    end

    // Scan from the round-robin pointer; ineligible requesters are skipped, not waited on.
    always_comb begin
        found   = 1'b0;
        win     = 2'd0;
        arb_idx = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            arb_idx = int'(rr_ptr_q) + k;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            if (!found && elig[arb_idx]) begin
                found = 1'b1;
                win   = 2'(arb_idx);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = found && (win == 2'(i)) && !nvdla_core_rst;
        end
    end

    assign win_need = need[win];
    assign win_pd   = req_pd[79*int'(win) +: 79];
    assign acc_mc   = found && req_ram_type[win];
    assign acc_cv   = found && !req_ram_type[win];

    always_comb begin
        mc_valid_d = mc_valid_q && !pdp2mcif_rd_req_ready;
        mc_pd_d    = mc_pd_q;
        cv_valid_d = cv_valid_q && !pdp2cvif_rd_req_ready;
        cv_pd_d    = cv_pd_q;
        if (acc_mc) begin
            mc_valid_d = 1'b1;
            mc_pd_d    = win_pd;
        end
        if (acc_cv) begin
            cv_valid_d = 1'b1;
            cv_pd_d    = win_pd;
        end
    end

    // A pop at full credit is dropped so avail never exceeds the FIFO depth.
    always_comb begin
        mc_dec   = acc_mc ? win_need : 16'd0;
        cv_dec   = acc_cv ? win_need : 16'd0;
        mc_inc   = (mcif_lat_fifo_pop && (mc_cdt_q != McFull)) ? 16'd1 : 16'd0;
        cv_inc   = (cvif_lat_fifo_pop && (cv_cdt_q != CvFull)) ? 16'd1 : 16'd0;
        mc_cdt_d = 9'({7'd0, mc_cdt_q} - mc_dec + mc_inc);
        cv_cdt_d = 9'({7'd0, cv_cdt_q} - cv_dec + cv_inc);
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        cq_valid_d = found;
        cq_id_d    = cq_id_q;
        if (found) begin
            cq_id_d = win;
            if (int'(win) + 1 >= int'(NREQ)) begin
                rr_ptr_d = 2'd0;
            end else begin
                rr_ptr_d = win + 2'd1;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            rr_ptr_q   <= 2'd0;
            mc_valid_q <= 1'b0;
            mc_pd_q    <= '0;
            cv_valid_q <= 1'b0;
            cv_pd_q    <= '0;
            mc_cdt_q   <= McFull;
            cv_cdt_q   <= CvFull;
            cq_valid_q <= 1'b0;
            cq_id_q    <= 2'd0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            mc_valid_q <= mc_valid_d;
            mc_pd_q    <= mc_pd_d;
            cv_valid_q <= cv_valid_d;
            cv_pd_q    <= cv_pd_d;
            mc_cdt_q   <= mc_cdt_d;
            cv_cdt_q   <= cv_cdt_d;
            cq_valid_q <= cq_valid_d;
            cq_id_q    <= cq_id_d;
        end
    end

    assign pdp2mcif_rd_req_valid = mc_valid_q;
    assign pdp2mcif_rd_req_pd    = mc_pd_q;
    assign pdp2cvif_rd_req_valid = cv_valid_q;
    assign pdp2cvif_rd_req_pd    = cv_pd_q;
    assign arb2cq_valid          = cq_valid_q;
    assign arb2cq_id             = cq_id_q;
    assign mc_cdt_avail          = mc_cdt_q;
    assign cv_cdt_avail          = cv_cdt_q;

    mc_pop_at_full_a: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(mcif_lat_fifo_pop && (mc_cdt_q == McFull)));
    cv_pop_at_full_a: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(cvif_lat_fifo_pop && (cv_cdt_q == CvFull)));

    // A request larger than its port's whole credit pool can never be granted.
    for (genvar g = 0; g < int'(NREQ); g++) begin : g_need_chk
        need_in_range_a: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
            !(req_valid[g] && (req_ram_type[g] ? (need[g] > 16'(MC_CDT))
                                               : (need[g] > 16'(CV_CDT)))));
    end

endmodule
